fetch_add: RTL and testbench

// - Next-fetch-address unit of the MIPS pipeline IF stage; sits between the PC register and the I-cache.
// - On an I-cache hit it advances the fetch address by INC.
// - On a miss it holds the address so the same fetch is replayed.
// - Result is registered (1-cycle latency).
// - Also reports a registered stall flag to the pipeline control.

---
 rtl/fetch_add_if.sv | 39 +++
 rtl/fetch_add.sv | 88 ++++++++
 tb/tb_fetch_add.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_add_if.sv
// Fetch-address bus between the PC/pipeline side and the next-fetch-address unit.
// Optional miss counters appear only when FETCH_ADD_MISS_CNT_EN is defined.
interface fetch_add_if #(
  parameter int AW = 32,
  parameter int CW = 16
);
  logic [AW-1:0] add_in;
  logic          hit;
  logic [AW-1:0] add_out;
  logic          stall;
`ifdef FETCH_ADD_MISS_CNT_EN
  logic [CW-1:0] miss_cnt;
  logic [CW-1:0] miss_run;
`endif

  modport master (
    output add_in,
    output hit,
    input  add_out,
    input  stall
`ifdef FETCH_ADD_MISS_CNT_EN
    ,
    input  miss_cnt,
    input  miss_run
`endif
  );

  modport slave (
    input  add_in,
    input  hit,
    output add_out,
    output stall
`ifdef FETCH_ADD_MISS_CNT_EN
    ,
    output miss_cnt,
    output miss_run
`endif
  );
endinterface

// File: rtl/fetch_add.sv
// Next-fetch-address unit: advances the PC by INC on an I-cache hit, replays it on a miss.
// Define FETCH_ADD_MISS_CNT_EN to add saturating total/consecutive miss counters.
module fetch_add #(
  parameter int              AW       = 32,
  parameter int unsigned     INC      = 4,
  parameter logic [AW-1:0]   RST_ADDR = {AW{1'b0}},
  parameter int              CW       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_add_if.slave   bus
);

  localparam logic [AW-1:0] INC_V = AW'(INC);

  logic [AW-1:0] add_q, add_d;
  logic          stall_q, stall_d;

  // Next address and stall flag from the current hit level
  always_comb begin
    add_d   = add_q;
    stall_d = stall_q;
    if (bus.hit) begin
      add_d   = bus.add_in + INC_V;
      stall_d = 1'b0;
    end else begin
      add_d   = bus.add_in;
      stall_d = 1'b1;
    end
  end

  // Address and stall registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_q   <= RST_ADDR;
      stall_q <= 1'b0;
    end else begin
      add_q   <= add_d;
      stall_q <= stall_d;
    end
  end

  assign bus.add_out = add_q;
  assign bus.stall   = stall_q;

`ifdef FETCH_ADD_MISS_CNT_EN
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] run_q, run_d;

  // Both counters saturate at all-ones; the run length restarts on any hit
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (bus.hit) begin
      run_d = {CW{1'b0}};
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (run_q != CNT_MAX) begin
        run_d = run_q + CNT_ONE;
      end else begin
        run_d = run_q;
      end
    end
  end

  // Counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
      run_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bus.miss_cnt = cnt_q;
  assign bus.miss_run = run_q;
`endif

endmodule

// File: tb/tb_fetch_add.sv
// Directed self-checking bench for fetch_add (counter tests only with FETCH_ADD_MISS_CNT_EN).
module tb_fetch_add;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_add_if #(.AW(32), .CW(4)) bus ();

  fetch_add #(.AW(32), .INC(4), .RST_ADDR(32'h0), .CW(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.add_in = 32'h40;
    bus.hit    = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.add_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_add_out got=%h exp=%h", bus.add_out, 32'h0);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
`ifdef FETCH_ADD_MISS_CNT_EN
    checks++;
    if (bus.miss_cnt !== 4'd0 || bus.miss_run !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters got cnt=%0d run=%0d exp=0,0", bus.miss_cnt, bus.miss_run);
    end
`endif
  endtask

  task automatic test_miss_hold();
    rst_n      = 1'b1;
    bus.add_in = 32'h1;
    bus.hit    = 1'b0;
    tick();
    checks++;
    if (bus.add_out !== 32'h1 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL miss_hold got add=%h stall=%b exp add=1 stall=1", bus.add_out, bus.stall);
    end
  endtask

  task automatic test_hit_advance();
    bus.add_in = 32'h1;
    bus.hit    = 1'b1;
    tick();
    checks++;
    if (bus.add_out !== 32'h5 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL hit_1 got add=%h stall=%b exp add=5 stall=0", bus.add_out, bus.stall);
    end
    bus.add_in = 32'h2;
    tick();
    checks++;
    if (bus.add_out !== 32'h6 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL hit_2 got add=%h stall=%b exp add=6 stall=0", bus.add_out, bus.stall);
    end
    bus.hit = 1'b0;
    tick();
    checks++;
    if (bus.add_out !== 32'h2 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL miss_after_hit got add=%h stall=%b exp add=2 stall=1", bus.add_out, bus.stall);
    end
  endtask

  task automatic test_wrap();
    bus.add_in = 32'hFFFF_FFFC;
    bus.hit    = 1'b1;
    tick();
    checks++;
    if (bus.add_out !== 32'h0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL wrap_fffc got add=%h stall=%b exp add=0 stall=0", bus.add_out, bus.stall);
    end
    bus.add_in = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (bus.add_out !== 32'h2) begin
      failures++;
      $display("FAIL wrap_fffe got add=%h exp add=2", bus.add_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.add_in = 32'h10;
    bus.hit    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.add_out !== 32'h10 || bus.stall !== 1'b1) begin
        failures++;
        $display("FAIL stall_run_%0d got add=%h stall=%b exp add=10 stall=1", i, bus.add_out, bus.stall);
      end
    end
    rst_n      = 1'b0;
    bus.add_in = 32'h20;
    tick();
    checks++;
    if (bus.add_out !== 32'h0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall got add=%h stall=%b exp add=0 stall=0", bus.add_out, bus.stall);
    end
    rst_n      = 1'b1;
    bus.hit    = 1'b1;
    bus.add_in = 32'h8;
    tick();
    checks++;
    if (bus.add_out !== 32'hC || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_hit got add=%h stall=%b exp add=c stall=0", bus.add_out, bus.stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v_add [6];
    logic        v_hit [6];
    logic [31:0] v_exp [6];
    v_add = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1004, 32'h0000_1004, 32'h8000_0003, 32'h7FFF_FFFC};
    v_hit = '{1'b1,          1'b0,          1'b0,          1'b1,          1'b1,          1'b1};
    v_exp = '{32'h0000_1004, 32'h0000_1004, 32'h0000_1004, 32'h0000_1008, 32'h8000_0007, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      bus.add_in = v_add[i];
      bus.hit    = v_hit[i];
      tick();
      checks++;
      if (bus.add_out !== v_exp[i] || bus.stall !== ~v_hit[i]) begin
        failures++;
        $display("FAIL b2b_%0d got add=%h stall=%b exp add=%h stall=%b",
                 i, bus.add_out, bus.stall, v_exp[i], ~v_hit[i]);
      end
    end
  endtask

`ifdef FETCH_ADD_MISS_CNT_EN
  task automatic test_miss_counters();
    logic [3:0] exp_v;
    rst_n   = 1'b0;
    bus.hit = 1'b1;
    tick();
    rst_n      = 1'b1;
    bus.hit    = 1'b0;
    bus.add_in = 32'h100;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_v = (i < 15) ? 4'(i + 1) : 4'd15;
      checks++;
      if (bus.miss_cnt !== exp_v || bus.miss_run !== exp_v) begin
        failures++;
        $display("FAIL miss_cnt_%0d got cnt=%0d run=%0d exp=%0d", i, bus.miss_cnt, bus.miss_run, exp_v);
      end
    end
    bus.hit = 1'b1;
    tick();
    checks++;
    if (bus.miss_run !== 4'd0 || bus.miss_cnt !== 4'd15) begin
      failures++;
      $display("FAIL miss_after_hit got cnt=%0d run=%0d exp cnt=15 run=0", bus.miss_cnt, bus.miss_run);
    end
    bus.hit = 1'b0;
    tick();
    checks++;
    if (bus.miss_run !== 4'd1 || bus.miss_cnt !== 4'd15) begin
      failures++;
      $display("FAIL miss_run_restart got cnt=%0d run=%0d exp cnt=15 run=1", bus.miss_cnt, bus.miss_run);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.add_in = 32'h0;
    bus.hit    = 1'b0;
    test_reset();
    test_miss_hold();
    test_hit_advance();
    test_wrap();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef FETCH_ADD_MISS_CNT_EN
    test_miss_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
